// File: rtl/base_adedup_pkg.sv
// Shared types and widths for the base_adedup slice: FSM state encoding,
// holdoff counter width and drop-statistics width.
package base_adedup_pkg;

  localparam int HOLD_W  = 8;
  localparam int STATS_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_EMPTY     = 3'd0;
  localparam state_t ST_OUT       = 3'd1;
  localparam state_t ST_OUT_PEND  = 3'd2;
  localparam state_t ST_HOLD      = 3'd3;
  localparam state_t ST_HOLD_PEND = 3'd4;

endpackage

// File: rtl/base_adedup_hold.sv
// Holdoff down-counter: loads on an output handshake, decrements while the
// parent idles, flags the cycle whose edge brings it to zero.
module base_adedup_hold
  import base_adedup_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              dec,
  output logic              zero_nxt
);

  logic [HOLD_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_nxt = (cnt_q <= HOLD_W'(1));

endmodule

// File: rtl/base_adedup.sv
// Valid/ready de-duplicator with a one-deep latest-wins pending slot and a
// post-handshake holdoff. Define BASE_ADEDUP_STATS_EN to add the s_drop counter.
module base_adedup
  import base_adedup_pkg::*;
#(
  parameter int width   = 1,
  parameter int holdoff = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  output logic             i_r,
  input  logic [0:width-1] i_d,
  output logic             o_v,
  input  logic             o_r,
  output logic [0:width-1] o_d
`ifdef BASE_ADEDUP_STATS_EN
  ,
  output logic [0:STATS_W-1] s_drop
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_LD   = HOLD_W'(holdoff);
  localparam bit                HOLD_ZERO = (holdoff == 0);

  state_t             state_q, state_d;
  logic [0:width-1]   out_q, out_d;
  logic [0:width-1]   pend_q, pend_d;
  logic               pend_v_q, pend_v_d;
  logic               ref_v_q;
  logic [0:width-1]   ref_val;
  logic               acc, dup, nd, hs;
  logic               ld_cnt, dec_cnt, cnt_last;

  // The output register keeps the last handed-off value once o_v drops,
  // so it doubles as the reference when no pending value exists.
  assign ref_val = pend_v_q ? pend_q : out_q;
  assign i_r     = reset;
  assign acc     = i_v & i_r;
  assign dup     = acc & ref_v_q & (i_d == ref_val);
  assign nd      = acc & ~dup;
  assign o_v     = (state_q == ST_OUT) || (state_q == ST_OUT_PEND);
  assign hs      = o_v & o_r;
  assign o_d     = out_q;
  assign dec_cnt = (state_q == ST_HOLD) || (state_q == ST_HOLD_PEND);

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ld_cnt   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (nd) begin
          out_d   = i_d;
          state_d = ST_OUT;
        end
      end
      ST_OUT, ST_OUT_PEND: begin
        if (hs && HOLD_ZERO) begin
          // Newest value goes straight out; an arriving beat beats the slot.
          pend_v_d = 1'b0;
          if (nd) begin
            out_d   = i_d;
            state_d = ST_OUT;
          end else if (pend_v_q) begin
            out_d   = pend_q;
            state_d = ST_OUT;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (hs) begin
          ld_cnt = 1'b1;
          if (nd) begin
            pend_d   = i_d;
            pend_v_d = 1'b1;
          end
          state_d = (nd || pend_v_q) ? ST_HOLD_PEND : ST_HOLD;
        end else if (nd) begin
          pend_d   = i_d;
          pend_v_d = 1'b1;
          state_d  = ST_OUT_PEND;
        end
      end
      ST_HOLD, ST_HOLD_PEND: begin
        if (cnt_last) begin
          pend_v_d = 1'b0;
          if (nd) begin
            out_d   = i_d;
            state_d = ST_OUT;
          end else if (pend_v_q) begin
            out_d   = pend_q;
            state_d = ST_OUT;
          end else begin
            state_d = ST_EMPTY;
          end
        end else if (nd) begin
          pend_d   = i_d;
          pend_v_d = 1'b1;
          state_d  = ST_HOLD_PEND;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_EMPTY;
      out_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ref_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ref_v_q  <= ref_v_q | acc;
    end
  end

  base_adedup_hold u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (ld_cnt),
    .load_val (HOLD_LD),
    .dec      (dec_cnt),
    .zero_nxt (cnt_last)
  );

`ifdef BASE_ADEDUP_STATS_EN
  logic [STATS_W-1:0] drop_q;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // A discarded pending value counts the same as a dropped duplicate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (dup || (nd && pend_v_q)) begin
      drop_q <= sat_inc(drop_q);
    end
  end

  assign s_drop = drop_q;
`endif

endmodule

// File: tb/tb_base_adedup.sv
// Scoreboard bench for base_adedup: one instance with holdoff=0, one with
// holdoff=3; s_drop checks are active when BASE_ADEDUP_STATS_EN is defined.
module tb_base_adedup;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       iv0, ir0, ov0, or0;
  logic [7:0] id0, od0;
  logic       iv3, ir3, ov3, or3;
  logic [7:0] id3, od3;
`ifdef BASE_ADEDUP_STATS_EN
  logic [15:0] sd0, sd3;
`endif

  int         n_chk = 0;
  int         n_err = 0;
  int         exp_drop = 0;
  logic [7:0] q0[$];
  logic [7:0] q3[$];
  logic [7:0] e0, e3, last0, v;
  logic       ivr;

  base_adedup #(.width(8), .holdoff(0)) dut0 (
    .clk(clk), .reset(reset), .i_v(iv0), .i_r(ir0), .i_d(id0),
    .o_v(ov0), .o_r(or0), .o_d(od0)
`ifdef BASE_ADEDUP_STATS_EN
    , .s_drop(sd0)
`endif
  );

  base_adedup #(.width(8), .holdoff(3)) dut3 (
    .clk(clk), .reset(reset), .i_v(iv3), .i_r(ir3), .i_d(id3),
    .o_v(ov3), .o_r(or3), .o_d(od3)
`ifdef BASE_ADEDUP_STATS_EN
    , .s_drop(sd3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat0(input logic [7:0] val);
    iv0 = 1'b1;
    id0 = val;
    cyc(1);
    iv0 = 1'b0;
  endtask

  task automatic drop_chk(input string tag);
`ifdef BASE_ADEDUP_STATS_EN
    chk(tag, 32'(sd0), 32'(exp_drop));
`endif
  endtask

  // Every output handshake must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (ov0 && or0) begin
      if (q0.size() == 0) chk("sb0_extra", 32'(q0.size()), 32'd1);
      else begin
        e0 = q0.pop_front();
        chk("sb0_data", 32'(od0), 32'(e0));
      end
    end
    if (ov3 && or3) begin
      if (q3.size() == 0) chk("sb3_extra", 32'(q3.size()), 32'd1);
      else begin
        e3 = q3.pop_front();
        chk("sb3_data", 32'(od3), 32'(e3));
      end
    end
  end

  initial begin
    reset = 1'b0;
    iv0 = 1'b0; id0 = '0; or0 = 1'b0;
    iv3 = 1'b0; id3 = '0; or3 = 1'b0;
    #12;
    chk("rst_ov0", 32'(ov0), 32'd0);
    chk("rst_od0", 32'(od0), 32'd0);
    chk("rst_ir0", 32'(ir0), 32'd0);
    chk("rst_ov3", 32'(ov3), 32'd0);
    chk("rst_od3", 32'(od3), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ir0_up", 32'(ir0), 32'd1);
    chk("ir3_up", 32'(ir3), 32'd1);
    chk("idle_ov0", 32'(ov0), 32'd0);

    // 05,05,07 back-to-back with o_r high
    or0 = 1'b1;
    q0.push_back(8'h05);
    q0.push_back(8'h07);
    iv0 = 1'b1; id0 = 8'h05;
    cyc(1);
    chk("t1_lat_ov", 32'(ov0), 32'd1);
    chk("t1_lat_od", 32'(od0), 32'h05);
    id0 = 8'h05;
    cyc(1);
    chk("t1_dup_ov", 32'(ov0), 32'd0);
    id0 = 8'h07;
    cyc(1);
    iv0 = 1'b0;
    chk("t1_ov7", 32'(ov0), 32'd1);
    chk("t1_od7", 32'(od0), 32'h07);
    cyc(2);
    exp_drop = 1;
    drop_chk("t1_drop");

    // back-pressure: 01,02,03 with o_r low, latest pending wins
    or0 = 1'b0;
    q0.push_back(8'h01);
    q0.push_back(8'h03);
    beat0(8'h01);
    beat0(8'h02);
    beat0(8'h03);
    chk("t2_stall_ov", 32'(ov0), 32'd1);
    chk("t2_stall_od", 32'(od0), 32'h01);
    cyc(2);
    chk("t2_stable_od", 32'(od0), 32'h01);
    exp_drop = 2;
    drop_chk("t2_drop");
    or0 = 1'b1;
    cyc(1);
    chk("t2_pend_ov", 32'(ov0), 32'd1);
    chk("t2_pend_od", 32'(od0), 32'h03);
    cyc(3);
    chk("t2_hold_od", 32'(od0), 32'h03);

    // repeat of a value that already left is still a duplicate
    q0.push_back(8'h20);
    beat0(8'h20);
    cyc(2);
    beat0(8'h20);
    chk("t3_dup_ov", 32'(ov0), 32'd0);
    q0.push_back(8'h21);
    beat0(8'h21);
    cyc(3);
    exp_drop = 3;
    drop_chk("t3_drop");

    // random stream, o_r=1 and holdoff=0: output is the run-collapsed input
    last0 = 8'h21;
    repeat (200) begin
      v   = 8'($urandom_range(0, 3));
      ivr = 1'($urandom_range(0, 1));
      if (ivr) begin
        if (v != last0) begin
          q0.push_back(v);
          last0 = v;
        end else begin
          exp_drop++;
        end
      end
      iv0 = ivr;
      id0 = v;
      cyc(1);
    end
    iv0 = 1'b0;
    cyc(3);
    drop_chk("rnd_drop");

    // holdoff=3: 0x10 handshaken at t, 0x11 at t+1, presented at t+4
    or3 = 1'b1;
    q3.push_back(8'h10);
    q3.push_back(8'h11);
    iv3 = 1'b1; id3 = 8'h10;
    cyc(1);
    chk("t4_t_ov", 32'(ov3), 32'd1);
    chk("t4_t_od", 32'(od3), 32'h10);
    id3 = 8'h11;
    cyc(1);
    iv3 = 1'b0;
    chk("t4_t1_ov", 32'(ov3), 32'd0);
    cyc(1);
    chk("t4_t2_ov", 32'(ov3), 32'd0);
    chk("t4_t2_od", 32'(od3), 32'h10);
    cyc(1);
    chk("t4_t3_ov", 32'(ov3), 32'd0);
    cyc(1);
    chk("t4_t4_ov", 32'(ov3), 32'd1);
    chk("t4_t4_od", 32'(od3), 32'h11);
    cyc(6);

    // asynchronous reset while OUT_PEND, then pre-reset value forwarded again
    or0 = 1'b0;
    beat0(8'h30);
    beat0(8'h31);
    chk("t5_pre_ov", 32'(ov0), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_ov", 32'(ov0), 32'd0);
    chk("t5_async_od", 32'(od0), 32'd0);
    chk("t5_async_ir", 32'(ir0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_drop = 0;
    @(posedge clk);
    #1;
    or0 = 1'b1;
    q0.push_back(8'h30);
    beat0(8'h30);
    chk("t5_fwd_ov", 32'(ov0), 32'd1);
    chk("t5_fwd_od", 32'(od0), 32'h30);
    cyc(3);
    drop_chk("t5_drop");

`ifdef BASE_ADEDUP_STATS_EN
    // saturation of the drop counter
    iv0 = 1'b1;
    id0 = 8'h30;
    cyc(70000);
    iv0 = 1'b0;
    cyc(1);
    chk("t6_sat", 32'(sd0), 32'hFFFF);
    iv0 = 1'b1;
    cyc(3);
    iv0 = 1'b0;
    cyc(1);
    chk("t6_stick", 32'(sd0), 32'hFFFF);
`endif

    for (int i = 0; i < 20 && (q0.size() != 0 || q3.size() != 0); i++) cyc(1);
    chk("sb0_left", 32'(q0.size()), 32'd0);
    chk("sb3_left", 32'(q3.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
